// File: rtl/iter_mdu_pkg.sv
// Shared constants for the multiply/divide unit: md_sel op codes, FSM state
// encodings and the accumulate mode used when MDU_MADD_EN is defined.
package iter_mdu_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;
    localparam logic [3:0] MD_MADDU = 4'd10;
    localparam logic [3:0] MD_MSUB  = 4'd11;
    localparam logic [3:0] MD_MSUBU = 4'd12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    typedef enum logic [1:0] {
        ACC_SET = 2'd0,
        ACC_ADD = 2'd1,
        ACC_SUB = 2'd2
    } acc_mode_e;

    function automatic logic is_read(input logic [3:0] sel);
        return (sel == MD_MFHI) || (sel == MD_MFLO);
    endfunction

endpackage

// File: rtl/iter_mdu_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
// master drives operands and op code, slave (the unit) returns stall and results.
interface iter_mdu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [3:0]       md_sel;
    logic             md_stall;
    logic [WIDTH-1:0] md_out;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    modport master (
        output d1, d2, md_sel,
        input  md_stall, md_out, hi_q, lo_q
    );

    modport slave (
        input  d1, d2, md_sel,
        output md_stall, md_out, hi_q, lo_q
    );
endinterface

// File: rtl/iter_mdu_div_core.sv
// Radix-2 restoring divider on magnitudes: WIDTH shift/subtract steps after load,
// then done is held for one fix-up cycle presenting sign-corrected results.
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int SW = $clog2(WIDTH + 1);

    logic             active;
    logic [SW-1:0]    steps;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH-1:0] dmag;
    logic [WIDTH-1:0] dividend_q;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic [WIDTH:0]   trial;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    // partial remainder stays below dmag, so a set top bit means the subtract underflowed
    assign trial = {part_rem, quo_sh[WIDTH-1]} - {1'b0, dmag};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active     <= 1'b0;
            steps      <= '0;
            part_rem   <= '0;
            quo_sh     <= '0;
            dmag       <= '0;
            dividend_q <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_zero   <= 1'b0;
        end else if (load) begin
            active     <= 1'b1;
            steps      <= SW'(WIDTH);
            part_rem   <= '0;
            quo_sh     <= mag(dividend, signed_op);
            dmag       <= mag(divisor, signed_op);
            dividend_q <= dividend;
            neg_q      <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r      <= signed_op & dividend[WIDTH-1];
            div_zero   <= (divisor == '0);
        end else if (active) begin
            if (steps != '0) begin
                steps <= steps - 1'b1;
                if (!trial[WIDTH]) begin
                    part_rem <= trial[WIDTH-1:0];
                    quo_sh   <= {quo_sh[WIDTH-2:0], 1'b1};
                end else begin
                    part_rem <= {part_rem[WIDTH-2:0], quo_sh[WIDTH-1]};
                    quo_sh   <= {quo_sh[WIDTH-2:0], 1'b0};
                end
            end else begin
                active <= 1'b0;
            end
        end
    end

    assign done = active && (steps == '0);

    always_comb begin
        quotient  = neg_q ? -quo_sh : quo_sh;
        remainder = neg_r ? -part_rem : part_rem;
        if (div_zero) begin
            quotient  = '1;
            remainder = dividend_q;
        end
    end

endmodule

// File: rtl/iter_mdu.sv
// Multiply/divide unit owning HI/LO: pipelined-latency multiply, iterative divide.
// Define MDU_MADD_EN to decode md_sel 9-12 as madd/maddu/msub/msubu.
//
// state   | meaning
// IDLE    | accepts start ops and mthi/mtlo
// MUL     | product held in tmp, counting down MULT_CYCLES
// DIV     | mdu_div_core iterating, HI/LO written on its done
module iter_mdu
    import iter_mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5
) (
    input logic       clk,
    input logic       reset,
    iter_mdu_if.slave md
);
    localparam int CNT_W = $clog2(MULT_CYCLES + 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [2*WIDTH-1:0] tmp;

    logic               mul_start;
    logic               div_start;
    logic               mul_signed;
    logic               div_signed;
    logic               busy;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mul_result;
    logic               div_done;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;
`ifdef MDU_MADD_EN
    acc_mode_e          acc_mode;
`endif

    always_comb begin
        mul_start  = 1'b0;
        div_start  = 1'b0;
        mul_signed = 1'b0;
        div_signed = 1'b0;
`ifdef MDU_MADD_EN
        acc_mode   = ACC_SET;
`endif
        case (md.md_sel)
            MD_MULT:  begin mul_start = 1'b1; mul_signed = 1'b1; end
            MD_MULTU: mul_start = 1'b1;
            MD_DIV:   begin div_start = 1'b1; div_signed = 1'b1; end
            MD_DIVU:  div_start = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD:  begin mul_start = 1'b1; mul_signed = 1'b1; acc_mode = ACC_ADD; end
            MD_MADDU: begin mul_start = 1'b1; acc_mode = ACC_ADD; end
            MD_MSUB:  begin mul_start = 1'b1; mul_signed = 1'b1; acc_mode = ACC_SUB; end
            MD_MSUBU: begin mul_start = 1'b1; acc_mode = ACC_SUB; end
`endif
            default: ;
        endcase
    end

    // extending to 2*WIDTH first makes the truncated product exact for both signednesses
    assign a_ext = mul_signed ? {{WIDTH{md.d1[WIDTH-1]}}, md.d1} : {{WIDTH{1'b0}}, md.d1};
    assign b_ext = mul_signed ? {{WIDTH{md.d2[WIDTH-1]}}, md.d2} : {{WIDTH{1'b0}}, md.d2};
    assign prod  = a_ext * b_ext;

`ifdef MDU_MADD_EN
    always_comb begin
        case (acc_mode)
            ACC_ADD: mul_result = {hi, lo} + prod;
            ACC_SUB: mul_result = {hi, lo} - prod;
            default: mul_result = prod;
        endcase
    end
`else
    assign mul_result = prod;
`endif

    mdu_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk      (clk),
        .reset    (reset),
        .load     (div_start && (state == ST_IDLE)),
        .signed_op(div_signed),
        .dividend (md.d1),
        .divisor  (md.d2),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            tmp   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (md.md_sel == MD_MTHI) hi <= md.d1;
                    if (md.md_sel == MD_MTLO) lo <= md.d1;
                    if (mul_start) begin
                        tmp   <= mul_result;
                        cnt   <= CNT_W'(MULT_CYCLES);
                        state <= ST_MUL;
                    end else if (div_start) begin
                        state <= ST_DIV;
                    end
                end
                ST_MUL: begin
                    if (cnt == CNT_W'(1)) begin
                        {hi, lo} <= tmp;
                        cnt      <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        hi    <= div_rem;
                        lo    <= div_quo;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state != ST_IDLE);
    assign md.md_stall = mul_start | div_start | busy;
    assign md.hi_q     = hi;
    assign md.lo_q     = lo;

    always_comb begin
        md.md_out = '0;
        if (is_read(md.md_sel)) md.md_out = (md.md_sel == MD_MFHI) ? hi : lo;
    end

endmodule
